msk_tk_inv_sched: RTL and testbench

Masked SKINNY TK1 tweakey scheduler for decryption. It accepts the d-share master key and fast-forwards it to the last-round key using the forward cell permutation PT. It then steps backward with the inverse permutation PT⁻¹, delivering round keys from round ROUNDS-1 down to 0 to the masked decryption datapath on demand. Every operation is share-wise linear: no logic ever combines two shares.

---
 rtl/msk_tk_pkg.sv | 31 +++
 rtl/msk_tk_perm.sv | 26 ++
 rtl/msk_tk_inv_sched.sv | 110 +++++++++++
 tb/tb_msk_tk_inv_sched.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/msk_tk_pkg.sv
// Shared constants and types for the masked SKINNY TK1 decryption tweakey scheduler.
// Holds the forward (PT) and inverse (PT_INV) cell permutations, widths and the FSM state type.
// No logic: imported by msk_tk_perm and msk_tk_inv_sched.
package msk_tk_pkg;

    localparam int CELL_W = 8;
    localparam int RIDX_W = 6;
    localparam int NCELL  = 16;

    // new[i] = old[PT[i]] for the forward step, new[i] = old[PT_INV[i]] for the inverse.
    localparam logic [3:0] PT [NCELL] = '{
        4'd9, 4'd15, 4'd8, 4'd13, 4'd10, 4'd14, 4'd12, 4'd11,
        4'd0, 4'd1,  4'd2, 4'd3,  4'd4,  4'd5,  4'd6,  4'd7
    };
    localparam logic [3:0] PT_INV [NCELL] = '{
        4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15,
        4'd2, 4'd0, 4'd4,  4'd7,  4'd6,  4'd3,  4'd5,  4'd1
    };

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FWD   = 2'd1,
        READY = 2'd2
    } state_t;

    // Source cell feeding destination cell i for the chosen direction.
    function automatic int perm_src(input int i, input bit inv);
        return inv ? int'(PT_INV[i]) : int'(PT[i]);
    endfunction

endpackage

// File: rtl/msk_tk_perm.sv
// Share-wise TK1 cell permutation (forward when INV=0, inverse when INV=1); pure wiring.
// Latency: combinational, 0 cycles.
// Backpressure: none; output follows input.
// Ports: key_in / key_out are d-share 128-bit keys, bit b of share s at index b*d+s.
module msk_tk_perm
    import msk_tk_pkg::*;
#(
    parameter int d   = 2,
    parameter bit INV = 1'b0
) (
    input  logic [128*d-1:0] key_in,
    output logic [128*d-1:0] key_out
);

    // Cell c occupies unshared bits 127-8c : 120-8c, so its LSB is 128-8(c+1).
    for (genvar s = 0; s < d; s++) begin : g_share
        for (genvar i = 0; i < NCELL; i++) begin : g_cell
            localparam int SRC = perm_src(i, INV);
            for (genvar k = 0; k < CELL_W; k++) begin : g_bit
                assign key_out[(128 - CELL_W*(i+1) + k)*d + s] =
                       key_in [(128 - CELL_W*(SRC+1) + k)*d + s];
            end
        end
    end

endmodule

// File: rtl/msk_tk_inv_sched.sv
// Masked SKINNY TK1 tweakey scheduler for decryption: forwards master key to round ROUNDS-1, then steps back on demand.
// Latency: rk_valid ROUNDS edges after start (1 edge with load_last); each backward step takes 1 cycle.
// Backpressure: rk_next is the consumer handshake; rk_out holds steady while rk_next is low.
// Ports: clk, rst (sync, active high), start, key_in, rk_next -> rk_out, rk_valid, rk_idx, busy, done.
// Optional: MSK_TK_LASTKEY_LOAD_EN adds load_last to load the last-round key directly.
module msk_tk_inv_sched
    import msk_tk_pkg::*;
#(
    parameter int d      = 2,
    parameter int ROUNDS = 40
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
`ifdef MSK_TK_LASTKEY_LOAD_EN
    input  logic                load_last,
`endif
    input  logic [128*d-1:0]    key_in,
    input  logic                rk_next,
    output logic [128*d-1:0]    rk_out,
    output logic                rk_valid,
    output logic [RIDX_W-1:0]   rk_idx,
    output logic                busy,
    output logic                done
);

    localparam logic [RIDX_W-1:0] LAST_IDX = RIDX_W'(ROUNDS - 1);

    state_t              state;
    logic [128*d-1:0]    key_q;
    logic [128*d-1:0]    key_fwd;
    logic [128*d-1:0]    key_inv;
    logic [RIDX_W-1:0]   cnt;
    logic                load_last_en;

`ifdef MSK_TK_LASTKEY_LOAD_EN
    assign load_last_en = load_last;
`else
    assign load_last_en = 1'b0;
`endif

    msk_tk_perm #(.d(d), .INV(1'b0)) u_perm_fwd (
        .key_in  (key_q),
        .key_out (key_fwd)
    );

    msk_tk_perm #(.d(d), .INV(1'b1)) u_perm_inv (
        .key_in  (key_q),
        .key_out (key_inv)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            key_q    <= '0;
            cnt      <= '0;
            rk_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // start has priority; rk_next is meaningless here.
                    if (start) begin
                        key_q <= key_in;
                        busy  <= 1'b1;
                        cnt   <= load_last_en ? LAST_IDX : '0;
                        if (load_last_en || (ROUNDS == 1)) begin
                            state    <= READY;
                            rk_valid <= 1'b1;
                        end else begin
                            state <= FWD;
                        end
                    end
                end
                FWD: begin
                    key_q <= key_fwd;
                    cnt   <= cnt + 1'b1;
                    if ((cnt + 1'b1) == LAST_IDX) begin
                        state    <= READY;
                        rk_valid <= 1'b1;
                    end
                end
                READY: begin
                    if (rk_next) begin
                        if (cnt != '0) begin
                            key_q <= key_inv;
                            cnt   <= cnt - 1'b1;
                        end else begin
                            // Round 0 consumed: wipe shares so no key material lingers.
                            key_q    <= '0;
                            state    <= IDLE;
                            rk_valid <= 1'b0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign rk_out = key_q;
    assign rk_idx = cnt;

endmodule

// File: tb/tb_msk_tk_inv_sched.sv
module tb_msk_tk_inv_sched;

    localparam int D = 2;
    localparam int W = 128*D;
    localparam int TB_PT [16] = '{9,15,8,13,10,14,12,11,0,1,2,3,4,5,6,7};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Three instances: ROUNDS = 2, 17, 40.
    logic start_a = 0, start_b = 0, start_c = 0;
    logic next_a = 0, next_b = 0, next_c = 0;
    logic ll_a = 0, ll_b = 0, ll_c = 0;
    logic [W-1:0] key_a = '0, key_b = '0, key_c = '0;
    logic [W-1:0] out_a, out_b, out_c;
    logic vld_a, vld_b, vld_c, busy_a, busy_b, busy_c, done_a, done_b, done_c;
    logic [5:0] idx_a, idx_b, idx_c;

    msk_tk_inv_sched #(.d(D), .ROUNDS(2)) u_a (
        .clk(clk), .rst(rst), .start(start_a),
`ifdef MSK_TK_LASTKEY_LOAD_EN
        .load_last(ll_a),
`endif
        .key_in(key_a), .rk_next(next_a), .rk_out(out_a), .rk_valid(vld_a),
        .rk_idx(idx_a), .busy(busy_a), .done(done_a));

    msk_tk_inv_sched #(.d(D), .ROUNDS(17)) u_b (
        .clk(clk), .rst(rst), .start(start_b),
`ifdef MSK_TK_LASTKEY_LOAD_EN
        .load_last(ll_b),
`endif
        .key_in(key_b), .rk_next(next_b), .rk_out(out_b), .rk_valid(vld_b),
        .rk_idx(idx_b), .busy(busy_b), .done(done_b));

    msk_tk_inv_sched #(.d(D), .ROUNDS(40)) u_c (
        .clk(clk), .rst(rst), .start(start_c),
`ifdef MSK_TK_LASTKEY_LOAD_EN
        .load_last(ll_c),
`endif
        .key_in(key_c), .rk_next(next_c), .rk_out(out_c), .rk_valid(vld_c),
        .rk_idx(idx_c), .busy(busy_c), .done(done_c));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] pack(input logic [127:0] s0, input logic [127:0] s1);
        logic [W-1:0] r;
        for (int b = 0; b < 128; b++) begin
            r[b*2]   = s0[b];
            r[b*2+1] = s1[b];
        end
        return r;
    endfunction

    function automatic logic [127:0] shr(input logic [W-1:0] bus, input int s);
        logic [127:0] r;
        for (int b = 0; b < 128; b++) r[b] = bus[b*2+s];
        return r;
    endfunction

    function automatic logic [127:0] fwd(input logic [127:0] x);
        logic [127:0] r;
        for (int i = 0; i < 16; i++)
            r[127-8*i -: 8] = x[127-8*TB_PT[i] -: 8];
        return r;
    endfunction

    function automatic logic [127:0] fwdn(input logic [127:0] x, input int n);
        logic [127:0] r = x;
        for (int i = 0; i < n; i++) r = fwd(r);
        return r;
    endfunction

    function automatic logic [127:0] umask(input logic [W-1:0] bus);
        return shr(bus, 0) ^ shr(bus, 1);
    endfunction

    logic [127:0] k0, rk1, b0, b1, c0, c1;
    logic [127:0] gold17 [17];
    logic [127:0] gold40 [40];
    logic [W-1:0] held;

    initial begin
        k0  = 128'h000102030405060708090A0B0C0D0E0F;
        rk1 = 128'h090F080D0A0E0C0B0001020304050607;

        // Reset state
        tick(); tick();
        rst = 1'b0;
        chk("rst_rk_out", out_c, '0);
        chk("rst_valid", {255'd0, vld_c}, '0);
        chk("rst_idx", {250'd0, idx_c}, '0);
        chk("rst_busy", {255'd0, busy_c}, '0);
        chk("rst_done", {255'd0, done_c}, '0);

        // ROUNDS=2 directed vector
        key_a = pack(k0, '0);
        start_a = 1; tick(); start_a = 0;
        chk("r2_busy", {255'd0, busy_a}, 256'd1);
        chk("r2_valid_early", {255'd0, vld_a}, '0);
        tick();
        chk("r2_valid", {255'd0, vld_a}, 256'd1);
        chk("r2_idx1", {250'd0, idx_a}, 256'd1);
        chk("r2_rk1", out_a, pack(rk1, '0));
        next_a = 1; tick(); next_a = 0;
        chk("r2_idx0", {250'd0, idx_a}, '0);
        chk("r2_rk0", out_a, pack(k0, '0));
        next_a = 1; tick(); next_a = 0;
        chk("r2_done", {255'd0, done_a}, 256'd1);
        chk("r2_done_busy", {255'd0, busy_a}, '0);
        chk("r2_done_valid", {255'd0, vld_a}, '0);
        chk("r2_done_zero", out_a, '0);
        tick();
        chk("r2_done_pulse", {255'd0, done_a}, '0);

        // ROUNDS=17 random shares: PT has order 16
        b0 = {$urandom, $urandom, $urandom, $urandom};
        b1 = {$urandom, $urandom, $urandom, $urandom};
        gold17[0] = b0 ^ b1;
        for (int i = 1; i < 17; i++) gold17[i] = fwd(gold17[i-1]);
        key_b = pack(b0, b1);
        start_b = 1; tick(); start_b = 0;
        for (int i = 0; i < 15; i++) tick();
        chk("r17_valid_early", {255'd0, vld_b}, '0);
        tick();
        chk("r17_valid", {255'd0, vld_b}, 256'd1);
        chk("r17_last_eq_key", out_b, pack(b0, b1));
        next_b = 1;
        for (int r = 16; r >= 0; r--) begin
            chk($sformatf("r17_idx%0d", r), {250'd0, idx_b}, W'(r));
            chk($sformatf("r17_gold%0d", r), {128'd0, umask(out_b)}, {128'd0, gold17[r]});
            tick();
        end
        next_b = 0;
        chk("r17_done", {255'd0, done_b}, 256'd1);

        // ROUNDS=40 with ignored start/rk_next during FWD
        c0 = 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;
        c1 = 128'h13579BDF02468ACE_FDB97531ECA86420;
        gold40[0] = c0 ^ c1;
        for (int i = 1; i < 40; i++) gold40[i] = fwd(gold40[i-1]);
        key_c = pack(c0, c1);
        start_c = 1; tick(); start_c = 0;
        for (int i = 1; i <= 38; i++) begin
            start_c = (i == 5) || (i == 20);
            next_c  = (i == 7) || (i == 30) || (i == 31);
            tick();
        end
        start_c = 0; next_c = 0;
        chk("r40_valid_early", {255'd0, vld_c}, '0);
        chk("r40_busy_fwd", {255'd0, busy_c}, 256'd1);
        tick();
        chk("r40_valid", {255'd0, vld_c}, 256'd1);
        chk("r40_idx39", {250'd0, idx_c}, 256'd39);
        chk("r40_gold39", {128'd0, umask(out_c)}, {128'd0, gold40[39]});
        chk("r40_shares39", out_c, pack(fwdn(c0, 39), fwdn(c1, 39)));

        // rk_next toggled 1,0,1,1
        next_c = 1; tick();
        chk("tog_idx38", {250'd0, idx_c}, 256'd38);
        chk("tog_gold38", {128'd0, umask(out_c)}, {128'd0, gold40[38]});
        held = pack(fwdn(c0, 38), fwdn(c1, 38));
        next_c = 0; tick();
        chk("tog_hold_idx", {250'd0, idx_c}, 256'd38);
        chk("tog_hold_key", out_c, held);
        next_c = 1; tick();
        chk("tog_idx37", {250'd0, idx_c}, 256'd37);
        tick();
        chk("tog_idx36", {250'd0, idx_c}, 256'd36);
        chk("tog_gold36", {128'd0, umask(out_c)}, {128'd0, gold40[36]});
        for (int i = 0; i < 36; i++) tick();
        chk("r40_idx0", {250'd0, idx_c}, '0);
        chk("r40_master", out_c, pack(c0, c1));
        tick(); next_c = 0;
        chk("r40_done", {255'd0, done_c}, 256'd1);
        chk("r40_zero", out_c, '0);

        // Reset in FWD, then a fresh run
        start_c = 1; tick(); start_c = 0;
        for (int i = 0; i < 20; i++) tick();
        chk("mid_busy_pre", {255'd0, busy_c}, 256'd1);
        rst = 1; tick(); rst = 0;
        chk("mid_rst_out", out_c, '0);
        chk("mid_rst_valid", {255'd0, vld_c}, '0);
        chk("mid_rst_idx", {250'd0, idx_c}, '0);
        chk("mid_rst_busy", {255'd0, busy_c}, '0);
        chk("mid_rst_done", {255'd0, done_c}, '0);
        start_c = 1; tick(); start_c = 0;
        for (int i = 0; i < 38; i++) tick();
        chk("re_valid_early", {255'd0, vld_c}, '0);
        tick();
        chk("re_valid", {255'd0, vld_c}, 256'd1);
        chk("re_gold39", {128'd0, umask(out_c)}, {128'd0, gold40[39]});
        next_c = 1;
        for (int i = 0; i < 40; i++) tick();
        next_c = 0;
        chk("re_done", {255'd0, done_c}, 256'd1);

`ifdef MSK_TK_LASTKEY_LOAD_EN
        // Direct last-key load
        key_c = pack(fwdn(c0, 39), fwdn(c1, 39));
        ll_c = 1; start_c = 1; tick(); start_c = 0; ll_c = 0;
        chk("ll_valid", {255'd0, vld_c}, 256'd1);
        chk("ll_idx39", {250'd0, idx_c}, 256'd39);
        next_c = 1;
        for (int i = 0; i < 39; i++) tick();
        next_c = 0;
        chk("ll_idx0", {250'd0, idx_c}, '0);
        chk("ll_master", out_c, pack(c0, c1));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
